mem_access: RTL



---
 rtl/mem_access.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: data-bus handshake, store lane alignment, load extension.
// Optional MISALIGN_TRAP_EN: misaligned memory ops trap instead of being force-aligned.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        stall,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;
    logic        ovalid_q, ovalid_d;
    logic [63:0] odata_q, odata_d;
    logic        omis_q, omis_d;

    logic [2:0]  amask;
    logic [7:0]  bmask;
    logic [63:0] aligned;
    logic [63:0] raw;
    logic [63:0] ext;
    logic        trap;
    logic        complete;

    always_comb begin
        amask = 3'b000;
        bmask = 8'h01;
        unique case (in_size)
            2'd0: begin amask = 3'b000; bmask = 8'h01; end
            2'd1: begin amask = 3'b001; bmask = 8'h03; end
            2'd2: begin amask = 3'b011; bmask = 8'h0F; end
            2'd3: begin amask = 3'b111; bmask = 8'hFF; end
        endcase
    end

    assign aligned = {in_addr[63:3], in_addr[2:0] & ~amask};

`ifdef MISALIGN_TRAP_EN
    assign trap = |(in_addr[2:0] & amask);
`else
    assign trap = 1'b0;
`endif

    // Load lane extraction uses the already-aligned captured address
    always_comb begin
        raw = dresp_data >> {addr_q[2:0], 3'b000};
        ext = raw;
        unique case (size_q)
            2'd0: ext = uns_q ? {56'd0, raw[7:0]}
                              : {{56{raw[7]}}, raw[7:0]};
            2'd1: ext = uns_q ? {48'd0, raw[15:0]}
                              : {{48{raw[15]}}, raw[15:0]};
            2'd2: ext = uns_q ? {32'd0, raw[31:0]}
                              : {{32{raw[31]}}, raw[31:0]};
            2'd3: ext = raw;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        uns_d    = uns_q;
        load_d   = load_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        ovalid_d = 1'b0;
        odata_d  = odata_q;
        omis_d   = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!(in_load || in_store)) begin
                        ovalid_d = 1'b1;
                        odata_d  = in_addr;
                    end else if (trap) begin
                        ovalid_d = 1'b1;
                        omis_d   = 1'b1;
                        odata_d  = in_addr;
                    end else begin
                        addr_d   = aligned;
                        size_d   = in_size;
                        uns_d    = in_unsigned;
                        load_d   = in_load;
                        strobe_d = in_store ? (bmask << aligned[2:0]) : 8'd0;
                        wdata_d  = in_store ? (in_wdata << {aligned[2:0], 3'b000})
                                            : 64'd0;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (dresp_addr_ok && dresp_data_ok) begin
                    complete = 1'b1;
                end else if (dresp_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d  = IDLE;
            ovalid_d = 1'b1;
            odata_d  = load_q ? ext : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            load_q   <= 1'b0;
            strobe_q <= '0;
            wdata_q  <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            omis_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            load_q   <= load_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            omis_q   <= omis_d;
        end
    end

    assign dreq_valid   = (state_q == REQ);
    assign dreq_addr    = addr_q;
    assign dreq_size    = size_q;
    assign dreq_strobe  = strobe_q;
    assign dreq_data    = wdata_q;
    assign stall        = (state_q != IDLE);
    assign out_valid    = ovalid_q;
    assign out_data     = odata_q;
    assign out_misalign = omis_q;

endmodule
